// File: rtl/nios2_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// nios2_jtag_scan_master
//
// Fabric-side JTAG scan engine that drives a Nios II virtual-JTAG debug slave.
// After reset it walks the TAP into Test-Logic-Reset and then Run-Test/Idle.
// From there it runs one IR scan (optional) followed by one DR scan per
// accepted command, capturing TDO during the DR shift bits.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   cmd_valid    command request
//   cmd_ready    engine idle in Run-Test/Idle (handshake with cmd_valid)
//   cmd_skip_ir  1 = DR scan only, IR left unchanged
//   cmd_ir       instruction to load, LSB shifted first
//   cmd_dr       data to shift in, LSB shifted first
//   rsp_valid    one-cycle pulse when a scan completes
//   rsp_dr       captured TDO bits, first-shifted bit at [0]
//   busy         inverse of cmd_ready
//   tck/tms/tdi  JTAG outputs to the target
//   tdo          JTAG data from the target
//
// Bit timing: a TCK bit is 2*TCK_DIV clk cycles, tck low for the first half
// and high for the second. tms/tdi change only on the clk edge that starts a
// bit (tck falling, or the command acceptance edge), so they are stable for a
// full TCK period around every rising edge.
// -----------------------------------------------------------------------------
module nios2_jtag_scan_master #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_skip_ir,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  // ---------------------------------------------------------------------------
  // Derived sizes and bit-index landmarks
  // ---------------------------------------------------------------------------
  localparam int MAX_W       = (DR_WIDTH > IR_WIDTH) ? DR_WIDTH : IR_WIDTH;
  localparam int BIT_CNT_MAX = MAX_W + 6;
  localparam int BIT_W       = $clog2(BIT_CNT_MAX + 1);
  localparam int DIV_W       = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

  // Test-Logic-Reset walk: bits 0..4, all with tms=1.
  localparam logic [BIT_W-1:0] TLR_LAST = BIT_W'(4);

  // IR scan: 1,1,0,0 preamble, IR_WIDTH shift bits, Update-IR, RTI.
  localparam logic [BIT_W-1:0] IR_PRE_LAST    = BIT_W'(1);
  localparam logic [BIT_W-1:0] IR_SHIFT_FIRST = BIT_W'(4);
  localparam logic [BIT_W-1:0] IR_SHIFT_LAST  = BIT_W'(4 + IR_WIDTH - 1);
  localparam logic [BIT_W-1:0] IR_UPDATE      = BIT_W'(4 + IR_WIDTH);
  localparam logic [BIT_W-1:0] IR_LAST        = BIT_W'(5 + IR_WIDTH);

  // DR scan: 1,0,0 preamble, DR_WIDTH shift bits, Update-DR, RTI.
  localparam logic [BIT_W-1:0] DR_PRE_LAST    = BIT_W'(0);
  localparam logic [BIT_W-1:0] DR_SHIFT_FIRST = BIT_W'(3);
  localparam logic [BIT_W-1:0] DR_SHIFT_LAST  = BIT_W'(3 + DR_WIDTH - 1);
  localparam logic [BIT_W-1:0] DR_UPDATE      = BIT_W'(3 + DR_WIDTH);
  localparam logic [BIT_W-1:0] DR_LAST        = BIT_W'(4 + DR_WIDTH);

  typedef enum logic [2:0] {
    ST_INIT_TLR = 3'd0,
    ST_INIT_RTI = 3'd1,
    ST_IDLE     = 3'd2,
    ST_IR_SCAN  = 3'd3,
    ST_DR_SCAN  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-bit tms/tdi tables for the two scan types
  // ---------------------------------------------------------------------------

  // tms for IR-scan bit idx: 1,1 | 0,0 | 0..0,1 (last shift) | 1 (update) | 0
  function automatic logic ir_bit_tms(input logic [BIT_W-1:0] idx);
    logic tms_v;
    if (idx <= IR_PRE_LAST) begin
      tms_v = 1'b1;
    end else if (idx < IR_SHIFT_LAST) begin
      tms_v = 1'b0;
    end else if (idx <= IR_UPDATE) begin
      tms_v = 1'b1;
    end else begin
      tms_v = 1'b0;
    end
    return tms_v;
  endfunction

  // tms for DR-scan bit idx: 1 | 0,0 | 0..0,1 (last shift) | 1 (update) | 0
  function automatic logic dr_bit_tms(input logic [BIT_W-1:0] idx);
    logic tms_v;
    if (idx <= DR_PRE_LAST) begin
      tms_v = 1'b1;
    end else if (idx < DR_SHIFT_LAST) begin
      tms_v = 1'b0;
    end else if (idx <= DR_UPDATE) begin
      tms_v = 1'b1;
    end else begin
      tms_v = 1'b0;
    end
    return tms_v;
  endfunction

  // tdi for IR-scan bit idx: instruction bits LSB first, 0 elsewhere
  function automatic logic ir_bit_tdi(input logic [BIT_W-1:0]    idx,
                                      input logic [IR_WIDTH-1:0] ir);
    logic [IR_WIDTH-1:0] ir_v;
    logic                tdi_v;
    if ((idx >= IR_SHIFT_FIRST) && (idx <= IR_SHIFT_LAST)) begin
      ir_v  = ir >> (idx - IR_SHIFT_FIRST);
      tdi_v = ir_v[0];
    end else begin
      ir_v  = '0;
      tdi_v = 1'b0;
    end
    return tdi_v;
  endfunction

  // tdi for DR-scan bit idx: data bits LSB first, 0 elsewhere
  function automatic logic dr_bit_tdi(input logic [BIT_W-1:0]    idx,
                                      input logic [DR_WIDTH-1:0] dr);
    logic [DR_WIDTH-1:0] dr_v;
    logic                tdi_v;
    if ((idx >= DR_SHIFT_FIRST) && (idx <= DR_SHIFT_LAST)) begin
      dr_v  = dr >> (idx - DR_SHIFT_FIRST);
      tdi_v = dr_v[0];
    end else begin
      dr_v  = '0;
      tdi_v = 1'b0;
    end
    return tdi_v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_r;
  logic [DIV_W-1:0]    div_r;
  logic [BIT_W-1:0]    bit_r;
  logic [IR_WIDTH-1:0] ir_r;
  logic [DR_WIDTH-1:0] dr_r;
  logic [DR_WIDTH-1:0] cap_r;

  logic                tick_s;
  logic                rise_s;
  logic                fall_s;
  logic                last_bit_s;
  logic                capture_s;
  logic [BIT_W-1:0]    bit_nxt_s;
  logic                nxt_tms_s;
  logic                nxt_tdi_s;

  // Divider terminal count, tck edge qualifiers and the next bit's tms/tdi
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    rise_s     = tick_s & ~tck;
    fall_s     = tick_s & tck;
    bit_nxt_s  = bit_r + BIT_W'(1);
    last_bit_s = 1'b0;
    nxt_tms_s  = 1'b1;
    nxt_tdi_s  = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_INIT_TLR: begin
        last_bit_s = (bit_r == TLR_LAST);
        nxt_tms_s  = 1'b1;
        nxt_tdi_s  = 1'b0;
      end
      ST_INIT_RTI: begin
        last_bit_s = 1'b1;
        nxt_tms_s  = 1'b0;
        nxt_tdi_s  = 1'b0;
      end
      ST_IR_SCAN: begin
        last_bit_s = (bit_r == IR_LAST);
        nxt_tms_s  = ir_bit_tms(bit_nxt_s);
        nxt_tdi_s  = ir_bit_tdi(bit_nxt_s, ir_r);
      end
      ST_DR_SCAN: begin
        last_bit_s = (bit_r == DR_LAST);
        nxt_tms_s  = dr_bit_tms(bit_nxt_s);
        nxt_tdi_s  = dr_bit_tdi(bit_nxt_s, dr_r);
        // only the DR shift bits contribute to the response
        if ((bit_r >= DR_SHIFT_FIRST) && (bit_r <= DR_SHIFT_LAST)) begin
          capture_s = rise_s;
        end else begin
          capture_s = 1'b0;
        end
      end
      default: begin
        last_bit_s = 1'b0;
        nxt_tms_s  = 1'b1;
        nxt_tdi_s  = 1'b0;
      end
    endcase
  end

  // Scan sequencer: TCK generation, TAP walk, TDO capture and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_INIT_TLR;
      div_r     <= '0;
      bit_r     <= '0;
      ir_r      <= '0;
      dr_r      <= '0;
      cap_r     <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // parked in Run-Test/Idle with tck low
          div_r <= '0;
          bit_r <= '0;
          tck   <= 1'b0;
          tdi   <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            // the acceptance edge is also the start of the first bit, and
            // both scan types open with tms=1 (Select-DR-Scan)
            ir_r      <= cmd_ir;
            dr_r      <= cmd_dr;
            cap_r     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            tms       <= 1'b1;
            state_r   <= cmd_skip_ir ? ST_DR_SCAN : ST_IR_SCAN;
          end else begin
            tms <= 1'b0;
          end
        end

        ST_INIT_TLR, ST_INIT_RTI, ST_IR_SCAN, ST_DR_SCAN: begin
          if (tick_s) begin
            div_r <= '0;
            tck   <= ~tck;
            if (capture_s) begin
              // shift right so the first captured bit ends up at [0]
              cap_r <= {tdo, cap_r[DR_WIDTH-1:1]};
            end
            if (fall_s) begin
              if (last_bit_s) begin
                bit_r <= '0;
                case (state_r)
                  ST_INIT_TLR: begin
                    state_r <= ST_INIT_RTI;
                    tms     <= 1'b0;
                    tdi     <= 1'b0;
                  end
                  ST_INIT_RTI: begin
                    state_r   <= ST_IDLE;
                    tms       <= 1'b0;
                    tdi       <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                  end
                  ST_IR_SCAN: begin
                    // DR scan follows with no idle bit in between
                    state_r <= ST_DR_SCAN;
                    tms     <= 1'b1;
                    tdi     <= 1'b0;
                  end
                  ST_DR_SCAN: begin
                    state_r   <= ST_IDLE;
                    tms       <= 1'b0;
                    tdi       <= 1'b0;
                    rsp_dr    <= cap_r;
                    rsp_valid <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                  end
                  default: begin
                    state_r <= ST_INIT_TLR;
                    tms     <= 1'b1;
                    tdi     <= 1'b0;
                  end
                endcase
              end else begin
                bit_r <= bit_nxt_s;
                tms   <= nxt_tms_s;
                tdi   <= nxt_tdi_s;
              end
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end

        default: begin
          // unreachable encoding: restart the TAP walk from scratch
          state_r   <= ST_INIT_TLR;
          div_r     <= '0;
          bit_r     <= '0;
          tck       <= 1'b0;
          tms       <= 1'b1;
          tdi       <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// tb_nios2_jtag_scan_master
//
// Two instances: dut (TCK_DIV=4) against a behavioural TAP controller whose
// DR echoes tdi one bit late, and dut1 (TCK_DIV=1) against a plain one-bit
// tdi echo. A vector table drives the main scans; hand-written sequences
// cover init, back-to-back commands and reset mid-scan.
// -----------------------------------------------------------------------------
module tb_nios2_jtag_scan_master;

  localparam logic [37:0] MASK = 38'h3F_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset;

  // TCK_DIV=4 instance
  logic        cmd_valid, cmd_ready, cmd_skip_ir;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_dr, rsp_dr;
  logic        rsp_valid, busy, tck, tms, tdi, tdo;

  // TCK_DIV=1 instance
  logic        cmd_valid_1, cmd_ready_1, cmd_skip_ir_1;
  logic [1:0]  cmd_ir_1;
  logic [37:0] cmd_dr_1, rsp_dr_1;
  logic        rsp_valid_1, busy_1, tck_1, tms_1, tdi_1, tdo_1;

  nios2_jtag_scan_master #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_skip_ir(cmd_skip_ir), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  nios2_jtag_scan_master #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
    .cmd_skip_ir(cmd_skip_ir_1), .cmd_ir(cmd_ir_1), .cmd_dr(cmd_dr_1),
    .rsp_valid(rsp_valid_1), .rsp_dr(rsp_dr_1), .busy(busy_1),
    .tck(tck_1), .tms(tms_1), .tdi(tdi_1), .tdo(tdo_1)
  );

  // ---------------------------------------------------------------------------
  // TAP controller model for the TCK_DIV=4 instance
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PDR;
      PDR:     return m ? EX2DR : PDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PIR;
      PIR:     return m ? EX2IR : PIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  tap_t        tap_st    = TLR;
  logic [1:0]  tap_ir_sh = 2'b00;
  logic [1:0]  tap_ir    = 2'b00;
  logic [37:0] tap_dr_sh = 38'h0;
  logic [37:0] tap_dr    = 38'h0;
  logic        echo      = 1'b0;
  int          ir_visits = 0;
  logic        echo_en   = 1'b0;

  always @(posedge tck) begin
    case (tap_st)
      SHIR:  tap_ir_sh <= {tdi, tap_ir_sh[1]};
      UPIR:  tap_ir    <= tap_ir_sh;
      CAPDR: echo      <= 1'b0;
      SHDR: begin
        tap_dr_sh <= {tdi, tap_dr_sh[37:1]};
        echo      <= tdi;
      end
      UPDR:  tap_dr    <= tap_dr_sh;
      SELIR: ir_visits <= ir_visits + 1;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  assign tdo = echo_en ? echo : 1'b0;

  // plain one-bit echo for the TCK_DIV=1 instance
  logic echo1 = 1'b0;
  always @(posedge tck_1) echo1 <= tdi_1;
  assign tdo_1 = echo1;

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command on the TCK_DIV=4 instance and wait for its response.
  // Called and returns at a negedge. Inputs are scrambled after acceptance.
  task automatic do_scan(input logic skip, input logic [1:0] ir, input logic [37:0] dr,
                         output int lat, output logic [37:0] rsp, output logic got);
    int n;
    int acc;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid   = 1'b1;
    cmd_skip_ir = skip;
    cmd_ir      = ir;
    cmd_dr      = dr;
    acc         = cyc + 1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_skip_ir = ~skip;
    cmd_ir      = ~ir;
    cmd_dr      = ~dr;
    got = 1'b0;
    lat = -1;
    rsp = '0;
    n   = 0;
    while (!got && n < 1000) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = cyc - acc;
        rsp = rsp_dr;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  typedef struct {
    logic        skip;
    logic [1:0]  ir;
    logic [37:0] dr;
    logic        echo_en;
    logic [1:0]  exp_ir;
    logic [37:0] exp_rsp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat;
    int          n;
    int          r0;
    int          acc;
    int          ea;
    int          eb;
    int          v0;
    int          rises;
    int          tdi_bad;
    int          no_toggle;
    int          rsp_seen;
    logic [5:0]  pat;
    logic        prev;
    logic        got;
    logic [37:0] rsp;

    vecs[0] = '{1'b0, 2'b10, 38'h2A_5A5A_5A5A, 1'b1, 2'b10, 38'h14_B4B4_B4B4, 408};
    vecs[1] = '{1'b1, 2'b01, 38'h3F_FFFF_FFFF, 1'b0, 2'b10, 38'h00_0000_0000, 344};
    vecs[2] = '{1'b0, 2'b01, 38'h00_0000_0001, 1'b1, 2'b01, 38'h00_0000_0002, 408};
    vecs[3] = '{1'b0, 2'b11, 38'h3F_FFFF_FFFF, 1'b1, 2'b11, 38'h3F_FFFF_FFFE, 408};
    vecs[4] = '{1'b1, 2'b00, 38'h15_5555_5555, 1'b1, 2'b11, 38'h2A_AAAA_AAAA, 344};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_skip_ir = 1'b0; cmd_ir = 2'b00; cmd_dr = '0;
    cmd_valid_1 = 1'b0; cmd_skip_ir_1 = 1'b0; cmd_ir_1 = 2'b00; cmd_dr_1 = '0;
    repeat (3) @(negedge clk);

    // reset values: {tck,tms,tdi,cmd_ready,busy,rsp_valid}
    check("reset_outputs", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b010010);
    check("reset_rsp_dr", rsp_dr, 38'h0);
    check("reset_outputs_div1", {tck_1, tms_1, tdi_1, cmd_ready_1, busy_1, rsp_valid_1}, 6'b010010);

    // ---- init sequence after reset release
    reset = 1'b0;
    r0 = cyc; pat = '0; rises = 0; tdi_bad = 0; prev = tck; n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (tck && !prev) begin
        pat = {pat[4:0], tms};
        rises++;
      end
      if (tdi !== 1'b0) tdi_bad++;
      prev = tck;
    end
    check("init_latency", cyc - r0, 48);
    check("init_tms_pattern", pat, 6'b111110);
    check("init_tck_rises", rises, 6);
    check("init_tdi_low", tdi_bad, 0);
    check("init_tap_rti", tap_st, RTI);
    check("init_ready_div1", cmd_ready_1, 1'b1);

    // ---- TCK_DIV=1: full scan in 102 cycles, tck toggling every clk
    cmd_valid_1 = 1'b1; cmd_skip_ir_1 = 1'b0; cmd_ir_1 = 2'b01; cmd_dr_1 = 38'h33_CC00_FF0F;
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid_1 = 1'b0; cmd_dr_1 = '0;
    prev = tck_1; no_toggle = 0; got = 1'b0; n = 0; lat = -1;
    while (!got && n < 500) begin
      @(negedge clk);
      n++;
      if (tck_1 === prev) no_toggle++;
      prev = tck_1;
      if (rsp_valid_1 === 1'b1) begin
        got = 1'b1;
        lat = cyc - acc;
        rsp = rsp_dr_1;
      end
    end
    check("div1_done", got, 1'b1);
    check("div1_latency", lat, 102);
    check("div1_rsp_dr", rsp, 38'h27_9801_FE1E);
    check("div1_tck_toggle", no_toggle, 0);

    // ---- table-driven scans on the TCK_DIV=4 instance
    for (int i = 0; i < 5; i++) begin
      echo_en = vecs[i].echo_en;
      v0 = ir_visits;
      do_scan(vecs[i].skip, vecs[i].ir, vecs[i].dr, lat, rsp, got);
      check($sformatf("vec%0d_done", i), got, 1'b1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_rsp_dr", i), rsp, vecs[i].exp_rsp);
      check($sformatf("vec%0d_ready_with_rsp", i), cmd_ready, 1'b1);
      check($sformatf("vec%0d_tap_ir", i), tap_ir, vecs[i].exp_ir);
      check($sformatf("vec%0d_tap_dr", i), tap_dr, vecs[i].dr);
      check($sformatf("vec%0d_ir_visits", i), ir_visits - v0, vecs[i].skip ? 0 : 1);
      check($sformatf("vec%0d_tap_rti", i), tap_st, RTI);
      @(negedge clk);
      check($sformatf("vec%0d_rsp_pulse", i), rsp_valid, 1'b0);
      check($sformatf("vec%0d_rsp_held", i), rsp_dr, vecs[i].exp_rsp);
    end

    // ---- back-to-back: cmd_valid held high across two commands
    echo_en = 1'b1;
    cmd_valid = 1'b1; cmd_skip_ir = 1'b0; cmd_ir = 2'b10; cmd_dr = 38'h00_1234_5678;
    @(negedge clk);
    cmd_ir = 2'b01; cmd_dr = 38'h3F_0000_0001;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ea = cyc;
    check("b2b_a_seen", rsp_valid, 1'b1);
    check("b2b_a_rsp_dr", rsp_dr, 38'h00_2468_ACF0);
    check("b2b_ready_in_rsp_cycle", cmd_ready, 1'b1);
    @(negedge clk);
    check("b2b_b_accepted", busy, 1'b1);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    eb = cyc;
    check("b2b_b_seen", rsp_valid, 1'b1);
    check("b2b_spacing", eb - ea, 409);
    check("b2b_b_rsp_dr", rsp_dr, 38'h3E_0000_0002);
    check("b2b_b_tap_ir", tap_ir, 2'b01);
    check("b2b_b_tap_dr", tap_dr, 38'h3F_0000_0001);
    @(negedge clk);

    // ---- reset during DR shift bit 20
    cmd_valid = 1'b1; cmd_skip_ir = 1'b0; cmd_ir = 2'b11; cmd_dr = 38'h2A_5A5A_5A5A;
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0; rsp_seen = 0;
    while (cyc < acc + 226 && n < 1000) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    check("abort_in_shift_dr", tap_st, SHDR);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b010010);
    check("abort_rsp_dr", rsp_dr, 38'h0);
    reset = 1'b0;
    r0 = cyc; n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    check("abort_reinit_latency", cyc - r0, 48);
    check("abort_no_rsp", rsp_seen, 0);
    check("abort_tap_rti", tap_st, RTI);
    check("abort_rsp_dr_after", rsp_dr, 38'h0);

    // recovery scan after the abort
    do_scan(vecs[0].skip, vecs[0].ir, vecs[0].dr, lat, rsp, got);
    check("recover_latency", lat, 408);
    check("recover_rsp_dr", rsp, (vecs[0].dr << 1) & MASK);
    check("recover_tap_dr", tap_dr, vecs[0].dr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
